// File: rtl/demux_pkg.sv
// Shared types and defaults for the TDM serial-to-parallel demultiplexer.
package demux_pkg;

    localparam int N_SLOTS_DEF = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int SEL_W_DEF = clog2(N_SLOTS_DEF);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/demux_1x8_dec.sv
// One-hot slot decoder driving the assembly-register write enables.
module demux_1x8_dec
    import demux_pkg::*;
#(
    parameter int N_SLOTS = N_SLOTS_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic [SEL_W-1:0]   slot,
    input  logic               enable,
    output logic [N_SLOTS-1:0] write_en
);

    always_comb begin
        write_en = '0;
        if (enable) begin
            write_en[slot] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_1x8.sv
// Serial-to-parallel TDM demultiplexer: assembles slot-ordered bits into a
// word and presents it on a registered valid/ready output.
module tdm_demux_1x8
    import demux_pkg::*;
#(
    parameter int N_SLOTS = N_SLOTS_DEF,
    parameter int SEL_W   = clog2(N_SLOTS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [N_SLOTS-1:0] Y,
    output logic               y_valid,
    input  logic               y_ready,
    output logic [SEL_W-1:0]   slot,
    output logic               overrun,
    output logic               sync_err
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   slot_q, slot_d, wr_idx;
    logic [N_SLOTS-1:0] asm_q, asm_d, asm_base, asm_merged, write_en;
    logic [N_SLOTS-1:0] y_q, y_d;
    logic               yv_q, yv_d, ovr_q, ovr_d, serr_q, serr_d;
    logic               take, resync, complete;

    demux_1x8_dec #(
        .N_SLOTS (N_SLOTS),
        .SEL_W   (SEL_W)
    ) u_dec (
        .slot     (wr_idx),
        .enable   (take),
        .write_en (write_en)
    );

    // A sync mid-frame restarts the word at slot 0 instead of realigning later.
    always_comb begin
        take       = din_valid && ((state_q == RECV) || frame_sync);
        resync     = din_valid && (state_q == RECV) && frame_sync && (slot_q != '0);
        wr_idx     = resync ? '0 : slot_q;
        asm_base   = resync ? '0 : asm_q;
        asm_merged = (asm_base & ~write_en) | ({N_SLOTS{din}} & write_en);
        complete   = take && (wr_idx == SEL_W'(N_SLOTS - 1));

        state_d = state_q;
        slot_d  = slot_q;
        asm_d   = asm_q;
        y_d     = y_q;
        yv_d    = yv_q;
        ovr_d   = 1'b0;
        serr_d  = resync;

        if (take) begin
            state_d = RECV;
            slot_d  = wr_idx + SEL_W'(1);
            asm_d   = complete ? '0 : asm_merged;
        end

        if (complete) begin
            y_d   = asm_merged;
            yv_d  = 1'b1;
            ovr_d = yv_q && !y_ready;
        end else if (yv_q && y_ready) begin
            yv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
            asm_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            asm_q   <= asm_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            ovr_q   <= ovr_d;
            serr_q  <= serr_d;
        end
    end

    assign Y        = y_q;
    assign y_valid  = yv_q;
    assign slot     = slot_q;
    assign overrun  = ovr_q;
    assign sync_err = serr_q;

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
Serial-to-parallel time-division demultiplexer, the receive-side counterpart of the 8:1 mux serialiser. It takes a one-bit stream in slot order 0..7 and routes each sampled bit to its slot position in an assembly register. It presents each completed word on a registered parallel output with a valid/ready handshake. It sits at the sink end of a serial link in the Mux_DeMux block group.

Parameters:
N_SLOTS, 8, number of slots per frame; must be a power of two and at least 2.
SEL_W, 3, slot index width; equals log2(N_SLOTS).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
din  input  1  serial data bit
din_valid  input  1  din is sampled this cycle
frame_sync  input  1  qualified by din_valid; marks the current bit as slot 0
Y  output  N_SLOTS  assembled word; Y[k] holds the bit received in slot k
y_valid  output  1  Y holds an unconsumed word
y_ready  input  1  consumer accepts Y when y_valid=1
slot  output  SEL_W  index of the next slot to be filled
overrun  output  1  one-cycle pulse: an unaccepted word was overwritten
sync_err  output  1  one-cycle pulse: frame_sync arrived when slot!=0

Behaviour:
- Single clock domain: clk. Reset rst is synchronous and active-high.
- Reset values: state=HUNT, slot=0, assembly register=0, Y=0, y_valid=0, overrun=0, sync_err=0. Reset mid-frame discards the partial word and any pending Y.
- Slot mapping is plain binary: a bit sampled with slot=k is written to assembly[k] only, through a one-hot write enable. Other assembly bits hold.
- A cycle with din_valid=0 changes nothing except the y_valid/y_ready handshake.
- FSM state HUNT:
  - din_valid && !frame_sync: bit ignored, slot stays 0.
  - din_valid && frame_sync: assembly[0]<=din, slot<=1, move to RECV.
- FSM state RECV, on din_valid:
  - frame_sync && slot!=0: sync_err pulses; the partial word is discarded (assembly cleared); din is written as slot 0; slot<=1; stay in RECV.
  - frame_sync && slot==0: normal.
  - !frame_sync && slot==0: accepted (flywheel). The stream continues without a sync on every frame.
  - Otherwise: assembly[slot]<=din, slot<=slot+1. Slot wraps from N_SLOTS-1 to 0.
- Word completion is the bit sampled at slot=N_SLOTS-1. On the next edge:
  - Y <= the assembly register with the final bit merged in.
  - y_valid <= 1.
  - assembly <= 0.
  - Latency from the last bit sample to valid Y is 1 cycle.
- Handshake:
  - y_valid && y_ready with no completion in the same cycle: y_valid<=0, Y holds its value.
  - Completion while y_valid && !y_ready: Y is overwritten with the new word, y_valid stays 1, overrun pulses for 1 cycle.
  - Completion with y_valid && y_ready in the same cycle: the new word loads, y_valid stays 1, no overrun.
- y_valid never depends combinationally on y_ready. All outputs are registered.

Decomposition:
- Shared package/header demux_pkg:
  - FSM state encodings: HUNT=1'b0, RECV=1'b1.
  - Default N_SLOTS/SEL_W localparams.
  - A clog2 helper function.
- One natural sub-module: demux_1x8_dec, a combinational one-hot slot decoder. Inputs: slot, enable. Output: write_en[N_SLOTS-1:0]. It is instantiated once for the assembly-register write enables.

Test Plan:
1. Reset; y_ready=1; feed din=1,0,1,1,0,0,1,0 for slots 0..7 with frame_sync on the first bit -> one cycle after the 8th bit, Y=8'h4D, y_valid=1 for 1 cycle, slot=0.
2. In HUNT, 5 bits with din_valid=1 and frame_sync=0 -> slot=0, y_valid=0, Y=8'h00. Then a frame_sync bit -> slot=1.
3. Same frame as test 1 with din_valid=0 gaps of 1-3 cycles between bits -> Y=8'h4D, y_valid rises exactly 1 cycle after the 8th valid bit.
4. y_ready=0; send word 8'h4D, then word 8'hA5 -> after the second word, Y=8'hA5, y_valid=1, overrun high for exactly 1 cycle. Raise y_ready -> y_valid=0 next cycle.
5. Start a frame; assert frame_sync on the 4th bit (slot=3) -> sync_err pulses; the partial word is not emitted; the following 8 bits (from that sync) produce the correct word. Also cover completion coinciding with y_ready=1 -> y_valid stays 1, no overrun.
6. Assert rst at slot=5 with y_valid=1 -> next cycle: Y=0, y_valid=0, slot=0, state=HUNT. A later bit without frame_sync is ignored.
